bist_controller: RTL and testbench
==================================

BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter WIDTH, default 8: width of both the pattern bus and the response bus; only 8 and 16 are supported.
REQ-002 Parameter NUM_PATTERNS, default 255: number of patterns applied per run; legal range 1..2^WIDTH-1.
REQ-003 Parameter SEED, default 8'h01 (zero-extended to WIDTH): initial LFSR state.
REQ-004 Parameter GOLDEN, default 0: expected MISR signature.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  request to begin a run; level-sampled.
REQ-008 cut_in  output  WIDTH  pattern driven into the combinational circuit-under-test (CUT) built from library cells.
REQ-009 cut_out  input  WIDTH  CUT response, combinationally derived from cut_in.
REQ-010 busy  output  1  high while in INIT, APPLY or COMPARE.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  signature == GOLDEN; valid only while done=1.
REQ-013 signature  output  WIDTH  current MISR contents.

Function
REQ-014 FSM states: IDLE, INIT, APPLY, COMPARE, DONE.
REQ-015 IDLE: start=1 -> INIT; otherwise stay in IDLE.
REQ-016 INIT lasts 1 cycle: LFSR <= SEED (1 if SEED==0), MISR <= 0, pattern counter <= 0; then -> APPLY.
REQ-017 APPLY: cut_in = LFSR every cycle; on each edge MISR absorbs cut_out, LFSR advances one step, counter increments; after NUM_PATTERNS edges -> COMPARE.
REQ-018 LFSR: Fibonacci, shift left, feedback into bit 0; WIDTH=8 taps {7,5,4,3}; WIDTH=16 taps {15,13,12,10}; maximal length; never all-zero.
REQ-019 MISR: Galois; next = (misr<<1) XOR (misr[MSB] ? POLY : 0) XOR cut_out; POLY = 8'h1D (WIDTH=8) or 16'h002D (WIDTH=16).
REQ-020 COMPARE lasts 1 cycle: registers pass = (MISR == GOLDEN); then -> DONE.
REQ-021 DONE: done=1; pass and signature held; start=1 -> INIT (restart); otherwise stay in DONE.
REQ-022 start is ignored in INIT, APPLY and COMPARE.
REQ-023 cut_in = 0 in IDLE, COMPARE and DONE.
REQ-024 Total latency from start sampled in IDLE to done=1: NUM_PATTERNS+2 cycles after the INIT edge.
REQ-025 Counter width = clog2(NUM_PATTERNS+1); no wrap within a run.

Reset
REQ-026 rst=1 at any edge, including mid-APPLY: state=IDLE, LFSR=SEED, MISR=0, counter=0, pass=0; outputs cut_in=0, busy=0, done=0, pass=0, signature=0.
REQ-027 rst has priority over start on the same edge.

Structure
REQ-028 Shared package bist_pkg: state enum, LFSR tap masks and MISR POLY constants for WIDTH 8 and 16.
REQ-029 One sub-module, bist_lfsr (seedable LFSR step); the MISR stays inline.

Verification
REQ-030 WIDTH=8, SEED=01, NUM_PATTERNS=4, cut_out = ~cut_in -> cut_in sequence 01,02,04,08; signature=8'h6C; pass=1 when GOLDEN=8'h6C.
REQ-031 Same run with cut_out tied to 0 -> signature=8'h00; pass=0 when GOLDEN=8'h6C.
REQ-032 NUM_PATTERNS=255, identity CUT -> LFSR visits 255 distinct non-zero values; done rises exactly 257 cycles after the INIT edge.
REQ-033 rst asserted on the 3rd APPLY cycle -> next cycle IDLE, busy=0, signature=0; a fresh start then reproduces REQ-030 values.
REQ-034 start held high throughout -> single run, DONE for exactly one cycle, then immediate INIT restart; start pulses during APPLY have no effect.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the LFSR/MISR built-in self-test controller:
// FSM encoding plus LFSR tap masks and MISR polynomials per supported width.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_APPLY   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } bist_state_t;

   // Tap masks select the bits XORed into bit 0 of the shift-left LFSR.
   localparam logic [15:0] LFSR_TAPS_W8  = 16'h00B8;
   localparam logic [15:0] LFSR_TAPS_W16 = 16'hB400;
   localparam logic [15:0] MISR_POLY_W8  = 16'h001D;
   localparam logic [15:0] MISR_POLY_W16 = 16'h002D;

   function automatic logic [15:0] lfsr_taps(input int width);
      if (width == 16) begin
         return LFSR_TAPS_W16;
      end else begin
         return LFSR_TAPS_W8;
      end
   endfunction

   function automatic logic [15:0] misr_poly(input int width);
      if (width == 16) begin
         return MISR_POLY_W16;
      end else begin
         return MISR_POLY_W8;
      end
   endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Next-state logic of a Fibonacci LFSR (shift left, feedback into bit 0).
// When load_i is set the seed is returned instead; an all-zero seed becomes 1.
module bist_lfsr
   import bist_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic fb_s;

   // Seed load or single LFSR step.
   always_comb begin
      fb_s   = ^(state_i & TAPS);
      next_o = {state_i[WIDTH-2:0], fb_s};
      if (load_i) begin
         if (seed_i == {WIDTH{1'b0}}) begin
            next_o = {{(WIDTH-1){1'b0}}, 1'b1};
         end else begin
            next_o = seed_i;
         end
      end else begin
         next_o = {state_i[WIDTH-2:0], fb_s};
      end
   end

endmodule

// File: rtl/bist_controller.sv
// BIST controller: drives LFSR patterns into a combinational CUT, compacts the
// responses in a Galois MISR and compares the final signature with GOLDEN.
module bist_controller
   import bist_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter int               NUM_PATTERNS = 255,
   parameter logic [WIDTH-1:0] SEED         = WIDTH'(8'h01),
   parameter logic [WIDTH-1:0] GOLDEN       = WIDTH'(1'b0)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] cut_in,
   input  logic [WIDTH-1:0] cut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);
   localparam logic [WIDTH-1:0] POLY     = WIDTH'(misr_poly(WIDTH));
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == {WIDTH{1'b0}}) ? WIDTH'(1'b1) : SEED;

   generate
      if (WIDTH != 8 && WIDTH != 16) begin : g_bad_width
         $error("bist_controller supports WIDTH 8 or 16 only");
      end
   endgenerate

   bist_state_t      state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_next_s;
   logic [WIDTH-1:0] misr_q, misr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] cut_in_q, cut_in_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             lfsr_load_s;

   assign lfsr_load_s = (state_q == ST_INIT);

   bist_lfsr #(
      .WIDTH (WIDTH)
   ) u_lfsr (
      .load_i  (lfsr_load_s),
      .seed_i  (SEED),
      .state_i (lfsr_q),
      .next_o  (lfsr_next_s)
   );

   // FSM next state, datapath next values and registered-output decode.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_INIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_INIT: begin
            lfsr_d  = lfsr_next_s;
            misr_d  = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            pass_d  = 1'b0;
            state_d = ST_APPLY;
         end
         ST_APPLY: begin
            lfsr_d = lfsr_next_s;
            misr_d = {misr_q[WIDTH-2:0], 1'b0}
                     ^ (misr_q[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                     ^ cut_out;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_COMPARE;
            end else begin
               state_d = ST_APPLY;
            end
         end
         ST_COMPARE: begin
            pass_d  = (misr_q == GOLDEN);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_INIT;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered, so decode them from the upcoming state.
      busy_d   = (state_d == ST_INIT) || (state_d == ST_APPLY) || (state_d == ST_COMPARE);
      done_d   = (state_d == ST_DONE);
      if (state_d == ST_APPLY) begin
         cut_in_d = lfsr_d;
      end else begin
         cut_in_d = {WIDTH{1'b0}};
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         lfsr_q   <= SEED_EFF;
         misr_q   <= {WIDTH{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         pass_q   <= 1'b0;
         cut_in_q <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         misr_q   <= misr_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
         cut_in_q <= cut_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign cut_in    = cut_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = misr_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: a 4-pattern instance with GOLDEN 8'h6C and
// a 255-pattern instance for the full LFSR period and latency.
module tb_bist_controller;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, start_a, busy_a, done_a, pass_a;
   logic [7:0] cut_in_a, cut_out_a, sig_a;
   logic [1:0] cut_mode;   // 0: inverting CUT, 1: tied to zero, 2: identity

   logic       rst_b, start_b, busy_b, done_b, pass_b;
   logic [7:0] cut_in_b, cut_out_b, sig_b;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0] exp_seq [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

   assign cut_out_a = (cut_mode == 2'd1) ? 8'h00 : ((cut_mode == 2'd2) ? cut_in_a : ~cut_in_a);
   assign cut_out_b = cut_in_b;

   bist_controller #(.WIDTH(8), .NUM_PATTERNS(4), .SEED(8'h01), .GOLDEN(8'h6C)) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .cut_in(cut_in_a), .cut_out(cut_out_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

   bist_controller #(.WIDTH(8), .NUM_PATTERNS(255), .SEED(8'h01), .GOLDEN(8'h00)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .cut_in(cut_in_b), .cut_out(cut_out_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_a = 1'b1; start_a = 1'b1;
      tick; tick;
      vec_cnt++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || cut_in_a !== 8'h00 || sig_a !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_outputs: busy=%b done=%b pass=%b cut_in=%h sig=%h, expected all zero",
                  busy_a, done_a, pass_a, cut_in_a, sig_a);
      end
      rst_a = 1'b0; start_a = 1'b0;
      tick;
      vec_cnt++;
      if (busy_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL idle_hold: busy=%b, expected 0", busy_a);
      end
   endtask

   task automatic test_inverse_cut;
      cut_mode = 2'd0;
      start_a = 1'b1; tick; start_a = 1'b0;
      vec_cnt++;
      if (busy_a !== 1'b1 || cut_in_a !== 8'h00 || done_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL init_state: busy=%b cut_in=%h done=%b, expected 1 00 0", busy_a, cut_in_a, done_a);
      end
      for (int j = 1; j <= 4; j++) begin
         tick;
         vec_cnt++;
         if (cut_in_a !== exp_seq[j-1]) begin
            err_cnt++;
            $display("FAIL inv_pattern%0d: cut_in=%h, expected %h", j, cut_in_a, exp_seq[j-1]);
         end
      end
      tick;
      vec_cnt++;
      if (busy_a !== 1'b1 || done_a !== 1'b0 || cut_in_a !== 8'h00 || sig_a !== 8'h6C) begin
         err_cnt++;
         $display("FAIL compare_state: busy=%b done=%b cut_in=%h sig=%h, expected 1 0 00 6c",
                  busy_a, done_a, cut_in_a, sig_a);
      end
      tick;
      vec_cnt++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== 1'b1 || sig_a !== 8'h6C) begin
         err_cnt++;
         $display("FAIL inv_done: done=%b busy=%b pass=%b sig=%h, expected 1 0 1 6c", done_a, busy_a, pass_a, sig_a);
      end
      tick;
      vec_cnt++;
      if (done_a !== 1'b1 || pass_a !== 1'b1 || sig_a !== 8'h6C) begin
         err_cnt++;
         $display("FAIL done_hold: done=%b pass=%b sig=%h, expected 1 1 6c", done_a, pass_a, sig_a);
      end
   endtask

   task automatic test_zero_cut;
      cut_mode = 2'd1;
      start_a = 1'b1; tick; start_a = 1'b0;
      tick;
      vec_cnt++;
      if (cut_in_a !== 8'h01) begin
         err_cnt++;
         $display("FAIL restart_seed: cut_in=%h, expected 01", cut_in_a);
      end
      repeat (5) tick;
      vec_cnt++;
      if (done_a !== 1'b1 || sig_a !== 8'h00 || pass_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL zero_done: done=%b sig=%h pass=%b, expected 1 00 0", done_a, sig_a, pass_a);
      end
   endtask

   task automatic test_reset_mid_apply;
      cut_mode = 2'd0;
      rst_a = 1'b1; tick; rst_a = 1'b0;
      start_a = 1'b1; tick; start_a = 1'b0;
      repeat (3) tick;
      vec_cnt++;
      if (sig_a !== 8'h1C || cut_in_a !== 8'h04) begin
         err_cnt++;
         $display("FAIL mid_apply: sig=%h cut_in=%h, expected 1c 04", sig_a, cut_in_a);
      end
      rst_a = 1'b1; start_a = 1'b1;
      tick;
      vec_cnt++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 8'h00 || cut_in_a !== 8'h00) begin
         err_cnt++;
         $display("FAIL mid_reset: busy=%b done=%b sig=%h cut_in=%h, expected 0 0 00 00", busy_a, done_a, sig_a, cut_in_a);
      end
      rst_a = 1'b0; start_a = 1'b0;
      tick;
      vec_cnt++;
      if (busy_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_priority: busy=%b, expected 0", busy_a);
      end
      start_a = 1'b1; tick; start_a = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         tick;
         if (j <= 4) begin
            vec_cnt++;
            if (cut_in_a !== exp_seq[j-1]) begin
               err_cnt++;
               $display("FAIL rerun_pattern%0d: cut_in=%h, expected %h", j, cut_in_a, exp_seq[j-1]);
            end
         end
      end
      vec_cnt++;
      if (done_a !== 1'b1 || sig_a !== 8'h6C || pass_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL rerun_done: done=%b sig=%h pass=%b, expected 1 6c 1", done_a, sig_a, pass_a);
      end
   endtask

   task automatic test_start_held;
      int done_cycles;
      cut_mode = 2'd0;
      done_cycles = 0;
      rst_a = 1'b1; tick; rst_a = 1'b0;
      start_a = 1'b1; tick;
      for (int j = 1; j <= 8; j++) begin
         tick;
         if (done_a === 1'b1) done_cycles++;
         if (j == 6) begin
            vec_cnt++;
            if (done_a !== 1'b1 || sig_a !== 8'h6C) begin
               err_cnt++;
               $display("FAIL held_done: done=%b sig=%h, expected 1 6c", done_a, sig_a);
            end
         end
         if (j == 7) begin
            vec_cnt++;
            if (done_a !== 1'b0 || busy_a !== 1'b1 || cut_in_a !== 8'h00) begin
               err_cnt++;
               $display("FAIL held_restart: done=%b busy=%b cut_in=%h, expected 0 1 00", done_a, busy_a, cut_in_a);
            end
         end
         if (j == 8) begin
            vec_cnt++;
            if (cut_in_a !== 8'h01 || sig_a !== 8'h00) begin
               err_cnt++;
               $display("FAIL held_reinit: cut_in=%h sig=%h, expected 01 00", cut_in_a, sig_a);
            end
         end
      end
      vec_cnt++;
      if (done_cycles !== 1) begin
         err_cnt++;
         $display("FAIL held_done_width: done cycles=%0d, expected 1", done_cycles);
      end
      start_a = 1'b0;
      repeat (5) tick;
      vec_cnt++;
      if (done_a !== 1'b1 || sig_a !== 8'h6C || pass_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL held_second_run: done=%b sig=%h pass=%b, expected 1 6c 1", done_a, sig_a, pass_a);
      end
   endtask

   task automatic test_full_period;
      bit seen [256];
      int j;
      int uniq;
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      uniq = 0;
      rst_b = 1'b1; tick; rst_b = 1'b0;
      vec_cnt++;
      if (busy_b !== 1'b0 || sig_b !== 8'h00 || done_b !== 1'b0) begin
         err_cnt++;
         $display("FAIL b_reset: busy=%b sig=%h done=%b, expected 0 00 0", busy_b, sig_b, done_b);
      end
      start_b = 1'b1; tick; start_b = 1'b0;
      j = 0;
      while (done_b !== 1'b1 && j < 400) begin
         tick;
         j++;
         if (j <= 255) begin
            vec_cnt++;
            if (cut_in_b === 8'h00 || seen[cut_in_b]) begin
               err_cnt++;
               $display("FAIL lfsr_value%0d: cut_in=%h, expected fresh non-zero", j, cut_in_b);
            end else begin
               uniq++;
            end
            seen[cut_in_b] = 1'b1;
         end
      end
      vec_cnt++;
      if (j !== 257) begin
         err_cnt++;
         $display("FAIL full_latency: done after %0d cycles, expected 257", j);
      end
      vec_cnt++;
      if (uniq !== 255) begin
         err_cnt++;
         $display("FAIL lfsr_distinct: %0d distinct, expected 255", uniq);
      end
   endtask

   initial begin
      cut_mode = 2'd0;
      rst_a = 1'b1; start_a = 1'b0;
      rst_b = 1'b1; start_b = 1'b0;
      test_reset;
      test_inverse_cut;
      test_zero_cut;
      test_reset_mid_apply;
      test_start_held;
      test_full_period;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
